// File: rtl/tcam2_match_arb_pkg.sv
// Shared types and default sizing for the TCAM2 match arbiter slice.
package tcam2_match_arb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ITEMS      = 16;
  localparam int DEF_CLIENTS    = 4;
  localparam int DEF_TAG_DEPTH  = 8;
  localparam int CLIENT_W       = $clog2(DEF_CLIENTS);
  localparam int TAG_CNT_W      = $clog2(DEF_TAG_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_MATCH = 2'd0,
    S_DRAIN = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/tcam2_tag_fifo.sv
// In-order FIFO of requester tags for matches currently inside TCAM2.
module tcam2_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
      if (push && !pop)      count_r <= count_r + 1'b1;
      else if (pop && !push) count_r <= count_r - 1'b1;
      else                   count_r <= count_r;
    end
  end

  // tag storage
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: rtl/tcam2_match_arb.sv
// Shares one TCAM2 between round-robin match clients and an atomic rule-write master.
module tcam2_match_arb
  import tcam2_match_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ITEMS      = DEF_ITEMS,
  parameter int CLIENTS    = DEF_CLIENTS,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH,
  localparam int ADDR_W    = $clog2(ITEMS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CLIENTS*DATA_WIDTH-1:0] cl_match_data,
  input  logic [CLIENTS-1:0]            cl_match_en,
  output logic [CLIENTS-1:0]            cl_match_rdy,
  output logic [CLIENTS-1:0]            cl_out_hit,
  output logic [CLIENTS*ITEMS-1:0]      cl_out_addr,
  output logic [CLIENTS-1:0]            cl_out_vld,
  input  logic [DATA_WIDTH-1:0]         cfg_wr_data,
  input  logic [DATA_WIDTH-1:0]         cfg_wr_mask,
  input  logic [ADDR_W-1:0]             cfg_wr_addr,
  input  logic                          cfg_wr_en,
  output logic                          cfg_wr_rdy,
  output logic [DATA_WIDTH-1:0]         tcam_write_data,
  output logic [DATA_WIDTH-1:0]         tcam_write_mask,
  output logic [ADDR_W-1:0]             tcam_write_addr,
  output logic                          tcam_write_en,
  input  logic                          tcam_write_rdy,
  output logic [DATA_WIDTH-1:0]         tcam_match_data,
  output logic                          tcam_match_en,
  input  logic                          tcam_match_rdy,
  input  logic                          tcam_match_out_hit,
  input  logic [ITEMS-1:0]              tcam_match_out_addr,
  input  logic                          tcam_match_out_vld,
  output logic                          err_unexp
);

  localparam int CLI_W = $clog2(CLIENTS);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  state_t             state_r, state_s;
  logic [CLI_W-1:0]   rr_ptr_r, grant_s, tag_s;
  logic               accept_s, pop_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]   tag_cnt_s;
  logic [CLIENTS-1:0] out_vld_r, out_hit_r;
  logic [CLIENTS*ITEMS-1:0] out_addr_r;
  logic               err_r;

  // round-robin pick: first requester at or after the pointer, wrapping
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_s = rr_ptr_r;
    for (int i = 0; i < CLIENTS; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!found && cl_match_en[idx]) begin
        grant_s = CLI_W'(idx);
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  end

  assign tcam_match_en   = (state_r == S_MATCH) && !cfg_wr_en && !fifo_full_s && (|cl_match_en);
  assign accept_s        = tcam_match_en && tcam_match_rdy;
  assign tcam_match_data = cl_match_data[grant_s*DATA_WIDTH +: DATA_WIDTH];
  assign pop_s           = tcam_match_out_vld && !fifo_empty_s;

  // one-hot handshake back to the granted client only
  always_comb begin
    cl_match_rdy = '0;
    if (accept_s) cl_match_rdy[grant_s] = 1'b1;
    else          cl_match_rdy = '0;
  end

  // FSM next state and write-port handshake
  always_comb begin
    state_s       = state_r;
    tcam_write_en = 1'b0;
    cfg_wr_rdy    = 1'b0;
    case (state_r)
      S_MATCH: if (cfg_wr_en) state_s = S_DRAIN; else state_s = S_MATCH;
      S_DRAIN: if (tag_cnt_s == '0) state_s = S_WRITE; else state_s = S_DRAIN;
      S_WRITE: begin
        tcam_write_en = 1'b1;
        cfg_wr_rdy    = tcam_write_rdy;
        if (tcam_write_rdy) state_s = S_MATCH; else state_s = S_WRITE;
      end
      default: state_s = S_MATCH;
    endcase
  end

  assign tcam_write_data = cfg_wr_data;
  assign tcam_write_mask = cfg_wr_mask;
  assign tcam_write_addr = cfg_wr_addr;

  // state and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_MATCH;
      rr_ptr_r <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) rr_ptr_r <= (grant_s == CLI_W'(CLIENTS - 1)) ? '0 : grant_s + 1'b1;
    end
  end

  tcam2_tag_fifo #(
    .WIDTH (CLI_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .pop   (pop_s),
    .wdata (grant_s),
    .rdata (tag_s),
    .count (tag_cnt_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // steer each result to the client whose tag is at the FIFO head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_r  <= '0;
      out_hit_r  <= '0;
      out_addr_r <= '0;
      err_r      <= 1'b0;
    end else begin
      out_vld_r <= '0;
      if (pop_s) begin
        out_vld_r[tag_s]                <= 1'b1;
        out_hit_r[tag_s]                <= tcam_match_out_hit;
        out_addr_r[tag_s*ITEMS +: ITEMS] <= tcam_match_out_addr;
      end
      if (tcam_match_out_vld && fifo_empty_s) err_r <= 1'b1;
    end
  end

  assign cl_out_vld  = out_vld_r;
  assign cl_out_hit  = out_hit_r;
  assign cl_out_addr = out_addr_r;
  assign err_unexp   = err_r;

endmodule

// File: tb/tb_tcam2_match_arb.sv
// Self-checking bench: table vectors, hand sequences and random traffic against a scoreboard model.
module tb_tcam2_match_arb;

  localparam int DW = 16;
  localparam int IT = 16;
  localparam int NC = 4;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC*DW-1:0] cl_match_data;
  logic [NC-1:0] cl_match_en, cl_match_rdy, cl_out_hit, cl_out_vld;
  logic [NC*IT-1:0] cl_out_addr;
  logic [DW-1:0] cfg_wr_data, cfg_wr_mask, tcam_write_data, tcam_write_mask, tcam_match_data;
  logic [3:0]    cfg_wr_addr, tcam_write_addr;
  logic          cfg_wr_en, cfg_wr_rdy, tcam_write_en, tcam_write_rdy;
  logic          tcam_match_en, tcam_match_rdy, tcam_match_out_hit, tcam_match_out_vld, err_unexp;
  logic [IT-1:0] tcam_match_out_addr;

  always #5 clk = ~clk;

  tcam2_match_arb #(.DATA_WIDTH(DW), .ITEMS(IT), .CLIENTS(NC), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_match_data(cl_match_data), .cl_match_en(cl_match_en), .cl_match_rdy(cl_match_rdy),
    .cl_out_hit(cl_out_hit), .cl_out_addr(cl_out_addr), .cl_out_vld(cl_out_vld),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_mask(cfg_wr_mask), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_rdy(cfg_wr_rdy),
    .tcam_write_data(tcam_write_data), .tcam_write_mask(tcam_write_mask),
    .tcam_write_addr(tcam_write_addr), .tcam_write_en(tcam_write_en), .tcam_write_rdy(tcam_write_rdy),
    .tcam_match_data(tcam_match_data), .tcam_match_en(tcam_match_en), .tcam_match_rdy(tcam_match_rdy),
    .tcam_match_out_hit(tcam_match_out_hit), .tcam_match_out_addr(tcam_match_out_addr),
    .tcam_match_out_vld(tcam_match_out_vld), .err_unexp(err_unexp)
  );

  // TCAM2 behavioural contents and pending results (in order, one per accepted match)
  logic [15:0] r_data [16];
  logic [15:0] r_mask [16];
  logic        r_vld  [16];
  typedef struct { int cl; logic hit; logic [15:0] addr; } pend_t;
  pend_t q[$];

  int          m_ptr, m_phase;
  logic [3:0]  exp_vld;
  logic        exp_hit [4];
  logic [15:0] exp_addr [4];
  logic        exp_err;
  logic        m_wr_done;
  int          checks, failures;

  typedef struct { logic [3:0] en; logic [3:0] exp_rdy; } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void tcam_eval(input logic [15:0] key, output logic hit, output logic [15:0] addr);
    hit  = 1'b0;
    addr = 16'h0;
    for (int i = 0; i < 16; i++)
      if (!hit && r_vld[i] && (((key ^ r_data[i]) & r_mask[i]) == 16'h0)) begin
        hit  = 1'b1;
        addr = 16'h1 << i;
      end
  endfunction

  // one clock: drive, check against model, advance model
  task automatic cycle(input logic [3:0] en, input logic [63:0] data, input logic trdy,
                       input logic deliver, input logic force_vld, input logic wen, input logic wrdy,
                       output logic [3:0] obs_rdy, output logic obs_en);
    int g, sz;
    logic mexp, have;
    logic [3:0] rexp;
    pend_t head, np;
    @(negedge clk);
    cl_match_en = en; cl_match_data = data; tcam_match_rdy = trdy;
    cfg_wr_en = wen; tcam_write_rdy = wrdy;
    sz   = q.size();
    have = (sz > 0);
    tcam_match_out_vld = deliver && (have || force_vld);
    if (have) begin
      tcam_match_out_hit = q[0].hit; tcam_match_out_addr = q[0].addr;
    end else begin
      tcam_match_out_hit = 1'($urandom); tcam_match_out_addr = 16'($urandom);
    end
    #1;
    mexp = (m_phase == 0) && !wen && (sz < TD) && (en != 4'h0);
    g = 0;
    for (int i = NC - 1; i >= 0; i--) if (en[(m_ptr + i) % NC]) g = (m_ptr + i) % NC;
    rexp = (mexp && trdy) ? (4'b0001 << g) : 4'b0000;
    obs_rdy = cl_match_rdy; obs_en = tcam_match_en;
    chk("match_en", tcam_match_en, mexp);
    chk("match_rdy", cl_match_rdy, rexp);
    if (mexp) chk("match_data", tcam_match_data, data[g*16 +: 16]);
    chk("write_en", tcam_write_en, m_phase == 2);
    chk("cfg_wr_rdy", cfg_wr_rdy, (m_phase == 2) && wrdy);
    if (m_phase == 2) begin
      chk("wr_addr", tcam_write_addr, cfg_wr_addr);
      chk("wr_data", tcam_write_data, cfg_wr_data);
      chk("wr_mask", tcam_write_mask, cfg_wr_mask);
    end
    chk("out_vld", cl_out_vld, exp_vld);
    for (int c = 0; c < NC; c++)
      if (exp_vld[c]) begin
        chk("out_hit", cl_out_hit[c], exp_hit[c]);
        chk("out_addr", cl_out_addr[c*16 +: 16], exp_addr[c]);
      end
    chk("err_unexp", err_unexp, exp_err);
    exp_vld = 4'h0;
    if (tcam_match_out_vld) begin
      if (have) begin
        head = q.pop_front();
        exp_vld[head.cl] = 1'b1;
        exp_hit[head.cl] = head.hit;
        exp_addr[head.cl] = head.addr;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (mexp && trdy) begin
      np.cl = g;
      tcam_eval(data[g*16 +: 16], np.hit, np.addr);
      q.push_back(np);
      m_ptr = (g + 1) % NC;
    end
    m_wr_done = 1'b0;
    case (m_phase)
      0: if (wen) m_phase = 1;
      1: if (sz == 0) m_phase = 2;
      2: if (wrdy) begin
        r_data[cfg_wr_addr] = cfg_wr_data; r_mask[cfg_wr_addr] = cfg_wr_mask;
        r_vld[cfg_wr_addr] = 1'b1; m_phase = 0; m_wr_done = 1'b1;
      end
      default: m_phase = 0;
    endcase
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cl_match_en = 4'h0; cl_match_data = 64'h0; cfg_wr_en = 1'b0;
    tcam_write_rdy = 1'b0; tcam_match_rdy = 1'b0; tcam_match_out_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_match_rdy", cl_match_rdy, 4'h0);
    chk("rst_out_vld", cl_out_vld, 4'h0);
    chk("rst_err", err_unexp, 1'b0);
    chk("rst_match_en", tcam_match_en, 1'b0);
    chk("rst_write_en", tcam_write_en, 1'b0);
    chk("rst_cfg_rdy", cfg_wr_rdy, 1'b0);
    q.delete(); m_ptr = 0; m_phase = 0; exp_vld = 4'h0; exp_err = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] orr;
    logic oe;
    int n;
    logic wr_act;
    checks = 0; failures = 0;
    cfg_wr_addr = 4'h0; cfg_wr_data = 16'h0; cfg_wr_mask = 16'h0;
    tcam_match_out_hit = 1'b0; tcam_match_out_addr = 16'h0;
    for (int i = 0; i < 16; i++) begin
      r_data[i] = 16'(i); r_mask[i] = 16'h000F; r_vld[i] = (i < 8);
    end
    for (int c = 0; c < NC; c++) begin exp_hit[c] = 1'b0; exp_addr[c] = 16'h0; end
    tbl[0]  = '{4'hF, 4'b0001}; tbl[1]  = '{4'hF, 4'b0010}; tbl[2]  = '{4'hF, 4'b0100};
    tbl[3]  = '{4'hF, 4'b1000}; tbl[4]  = '{4'hF, 4'b0001}; tbl[5]  = '{4'hF, 4'b0010};
    tbl[6]  = '{4'h4, 4'b0100}; tbl[7]  = '{4'hC, 4'b1000}; tbl[8]  = '{4'hC, 4'b0100};
    tbl[9]  = '{4'h3, 4'b0001}; tbl[10] = '{4'h3, 4'b0010}; tbl[11] = '{4'h0, 4'b0000};
    tbl[12] = '{4'h0, 4'b0000};
    rst_n = 1'b0;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].en, 64'h0004_0003_0002_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
      chk("tbl_grant", orr, tbl[i].exp_rdy);
    end

    // tag FIFO fills at TAG_DEPTH while results are held back
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(4'hF, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);
      if (orr != 4'h0) n++;
      if (k >= 8) chk("full_blocks", oe, 1'b0);
    end
    chk("full_accepts", n, 8);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(4'hF, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
      if (orr != 4'h0) n++;
    end
    chk("accept_per_pop", n, 3);
    for (int k = 0; k < 20 && q.size() > 0; k++)
      cycle(4'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
    chk("drained", q.size(), 0);
    cycle(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);

    // atomic write with 3 matches outstanding
    for (int k = 0; k < 3; k++) cycle(4'h1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);
    cfg_wr_addr = 4'd5; cfg_wr_data = 16'h00AB; cfg_wr_mask = 16'hFFFF;
    m_wr_done = 1'b0;
    for (int k = 0; k < 40 && !m_wr_done; k++)
      cycle(4'hF, {$urandom, $urandom}, 1'b1, k >= 2, 1'b0, 1'b1, 1'($urandom), orr, oe);
    chk("write_done", m_wr_done, 1'b1);
    cycle(4'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
    cycle(4'h2, 64'h0000_0000_00AB_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);
    cycle(4'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
    #1;
    chk("new_rule_vld", cl_out_vld, 4'b0010);
    chk("new_rule_hit", cl_out_hit[1], 1'b1);
    chk("new_rule_addr", cl_out_addr[31:16], 16'h0020);

    // unexpected result with empty FIFO
    cycle(4'h0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, orr, oe);
    for (int k = 0; k < 3; k++) cycle(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);
    #1;
    chk("err_sticky", err_unexp, 1'b1);

    // reset while draining with 2 outstanding
    for (int k = 0; k < 2; k++) cycle(4'h1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, orr, oe);
    cycle(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, orr, oe);
    cycle(4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, orr, oe);
    do_reset();
    cycle(4'hF, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, orr, oe);
    chk("post_rst_grant0", orr, 4'b0001);

    // random traffic with occasional rule writes
    wr_act = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!wr_act && ($urandom % 40 == 0)) begin
        wr_act = 1'b1;
        cfg_wr_addr = 4'($urandom); cfg_wr_data = 16'($urandom); cfg_wr_mask = 16'($urandom) | 16'hFF00;
      end
      cycle(4'($urandom), {$urandom, $urandom}, ($urandom % 4) != 0, ($urandom % 3) != 0,
            1'b0, wr_act, 1'($urandom), orr, oe);
      if (m_wr_done) wr_act = 1'b0;
    end
    for (int k = 0; k < 20; k++) cycle(4'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, orr, oe);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
